kenny_speaker_translator: RTL
=============================

# kenny_speaker_translator

I2S transmitter that drives an external I2S DAC/amplifier from parallel stereo samples. It generates BCLK and LRCLK and serialises 18-bit two's-complement samples MSB-first on DIN. It is the output-side counterpart of the microphone receiver and sits between the audio processing datapath and the speaker amplifier pins. A 2-entry sample FIFO with a valid/ready handshake decouples the producer from the fixed I2S frame rate.

## Interface
- SAMPLE_W, 18: sample width in bits, two's complement.
- SLOT_W, 32: BCLK periods per channel slot. Must satisfy SLOT_W ≥ SAMPLE_W+1.
- HALF_DIV, 2: clk cycles per BCLK half-period. Must be ≥ 1.
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer holds a valid stereo pair.
- in_ready  out  1  FIFO not full; a push occurs when in_valid && in_ready.
- in_left  in  SAMPLE_W  left sample.
- in_right  in  SAMPLE_W  right sample.
- BCLK  out  1  serial bit clock to the DAC.
- LRCLK  out  1  word select; 0 = left slot, 1 = right slot.
- DIN  out  1  serial data to the DAC.
- frame_start  out  1  one-clk pulse when the left slot begins.
- underrun  out  1  one-clk pulse when a frame starts with the FIFO empty.

## Operation
- Divider: div_cnt counts 0..HALF_DIV-1. On wrap, BCLK toggles.
- "Fall event" = the clk edge where BCLK goes 1→0. At a fall event:
  - bit_cnt advances 0..SLOT_W-1.
  - On wrap, LRCLK toggles.
  - DIN and LRCLK update only on fall events. The DAC samples DIN on BCLK rise.
- Slot bit map (I2S, one-bit delay):
  - bit_cnt 0 → DIN = 0.
  - bit_cnt k in 1..SAMPLE_W → DIN = sample[SAMPLE_W-k], MSB first.
  - bit_cnt > SAMPLE_W → DIN = 0.
- Frame start: the fall event where LRCLK goes 1→0 and bit_cnt goes to 0.
  - FIFO non-empty: pop the head; load left into the shift register and right into the hold register. frame_start = 1.
  - FIFO empty: load zeros into both; frame_start = 1 and underrun = 1. Silence is output for the whole frame.
- Right slot start (LRCLK 0→1): load the hold register into the shift register. No FIFO access.
- FIFO: 2 entries of {left, right}.
  - in_ready = !full.
  - A push and a pop in the same cycle are both performed.
  - A push into an empty FIFO on the frame-start edge is not bypassed: that frame underruns and the pushed pair plays next frame.
  - A pop frees a slot; in_ready rises on the following cycle.
- Reset (asynchronous, any time, including mid-frame):
  - BCLK = 1, LRCLK = 1, DIN = 0, in_ready = 0.
  - frame_start = 0, underrun = 0.
  - div_cnt = 0, bit_cnt = SLOT_W-1, FIFO flushed, shift and hold registers cleared.
  - in_ready goes to 1 on the first clk edge after release.

## Timing
- All outputs are registered; nothing combinational from input to output.
- First fall event: the HALF_DIV-th posedge after reset release. It is a frame start (LRCLK→0, pop or underrun).
- BCLK period = 2·HALF_DIV clk. Frame = 2·SLOT_W BCLK = 4·HALF_DIV·SLOT_W clk.
  - Defaults: 256 clk per frame.
- MSB appears on DIN at the fall event one BCLK after the LRCLK change, i.e. 2·HALF_DIV clk after frame_start.
- Latency from a push into an empty FIFO to MSB on DIN: at most one frame + 2·HALF_DIV clk.

## Structure
- Shared package kenny_audio_pkg:
  - SAMPLE_W and SLOT_W defaults.
  - stereo_sample_t packed struct {left, right}.
  - Also used by the microphone receiver.
- Sub-module kenny_sample_fifo2: 2-deep FIFO of stereo_sample_t with push/pop/full/empty and asynchronous active-low reset.
- Divider, bit/slot counters and shifter stay in the top module.

## Test plan
All with defaults: SAMPLE_W=18, SLOT_W=32, HALF_DIV=2.
- Reset release, no input:
  - BCLK toggles every 2 clk.
  - LRCLK low for 128 clk and high for 128 clk.
  - frame_start and underrun pulse every 256 clk; DIN stays 0.
- Push left=18'h2AAAA, right=18'h15555 → next frame:
  - DIN bits 1..18 of the left slot = 10_1010_1010_1010_1010.
  - Right slot = 01_0101_0101_0101_0101; bits 0 and 19..31 are 0.
  - underrun = 0 for that frame.
- Producer holds in_valid high continuously:
  - Exactly two pushes are accepted, then in_ready = 0.
  - Thereafter exactly one push per 256 clk; consecutive frames play the pairs in order with no underrun.
- Push on the exact frame-start clk into an empty FIFO:
  - underrun pulses and the frame is silent.
  - The pushed pair plays on the following frame.
- Assert reset at bit_cnt=10 of the right slot:
  - Outputs go to reset values immediately and the FIFO empties.
  - After release, the first frame_start occurs 2 clk later with underrun = 1.
- Sign extremes: left=18'h20000, right=18'h1FFFF → left slot bit 1 = 1 then 17 zeros; right slot bit 1 = 0 then 17 ones.

Source files
------------

// File: rtl/kenny_audio_pkg.sv
// Shared audio types for the I2S speaker transmitter and microphone receiver.
package kenny_audio_pkg;
  localparam int KENNY_SAMPLE_W = 18;
  localparam int KENNY_SLOT_W   = 32;

  typedef struct packed {
    logic [KENNY_SAMPLE_W-1:0] left;
    logic [KENNY_SAMPLE_W-1:0] right;
  } stereo_sample_t;
endpackage

// File: rtl/kenny_sample_fifo2.sv
// Two-entry FIFO of stereo pairs; full_nxt lets the owner register its ready flag.
module kenny_sample_fifo2
  import kenny_audio_pkg::*;
#(
  parameter type T = stereo_sample_t
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  T     wdata,
  output T     rdata,
  output logic full,
  output logic empty,
  output logic full_nxt
);
  T           mem_q [2];
  T           mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       do_push, do_pop;

  always_comb begin
    do_push  = push && (cnt_q != 2'd2);
    do_pop   = pop && (cnt_q != 2'd0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) rd_ptr_d = ~rd_ptr_q;
    cnt_d    = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    full_nxt = (cnt_d == 2'd2);
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/kenny_speaker_translator.sv
// I2S transmitter: BCLK/LRCLK generation and MSB-first serialisation of
// stereo pairs drawn from a 2-entry FIFO, one pair per frame.
module kenny_speaker_translator
  import kenny_audio_pkg::*;
#(
  parameter int SAMPLE_W = KENNY_SAMPLE_W,
  parameter int SLOT_W   = KENNY_SLOT_W,
  parameter int HALF_DIV = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] in_left,
  input  logic [SAMPLE_W-1:0] in_right,
  output logic                BCLK,
  output logic                LRCLK,
  output logic                DIN,
  output logic                frame_start,
  output logic                underrun
);
  localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int BIT_W = $clog2(SLOT_W);

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } pair_t;

  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                bclk_q, bclk_d, lrclk_q, lrclk_d, din_q, din_d;
  logic                frame_start_q, frame_start_d, underrun_q, underrun_d;
  logic                in_ready_q, in_ready_d;
  logic [SAMPLE_W-1:0] sh_q, sh_d, hold_q, hold_d;
  logic                div_wrap, fall, slot_wrap, frame_edge, right_edge;
  logic                push, pop, fifo_full, fifo_empty, fifo_full_nxt;
  pair_t               wr_pair, head;

  assign wr_pair = {in_left, in_right};

  kenny_sample_fifo2 #(.T(pair_t)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .wdata    (wr_pair),
    .rdata    (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .full_nxt (fifo_full_nxt)
  );

  always_comb begin
    div_wrap      = (div_cnt_q == DIV_W'(HALF_DIV - 1));
    div_cnt_d     = div_wrap ? '0 : div_cnt_q + 1'b1;
    bclk_d        = div_wrap ? ~bclk_q : bclk_q;
    fall          = div_wrap && bclk_q;
    slot_wrap     = (bit_cnt_q == BIT_W'(SLOT_W - 1));
    frame_edge    = fall && slot_wrap && lrclk_q;
    right_edge    = fall && slot_wrap && !lrclk_q;
    // No bypass: a pair pushed on the frame-start edge waits for the next frame.
    pop           = frame_edge && !fifo_empty;
    push          = in_valid && in_ready_q && !fifo_full;
    in_ready_d    = !fifo_full_nxt;
    frame_start_d = frame_edge;
    underrun_d    = frame_edge && fifo_empty;
    bit_cnt_d     = bit_cnt_q;
    lrclk_d       = lrclk_q;
    din_d         = din_q;
    sh_d          = sh_q;
    hold_d        = hold_q;
    if (fall) begin
      bit_cnt_d = slot_wrap ? '0 : bit_cnt_q + 1'b1;
      lrclk_d   = slot_wrap ? ~lrclk_q : lrclk_q;
      din_d     = 1'b0;
      if (frame_edge) begin
        sh_d   = fifo_empty ? '0 : head.left;
        hold_d = fifo_empty ? '0 : head.right;
      end else if (right_edge) begin
        sh_d = hold_q;
      end else if (bit_cnt_q < BIT_W'(SAMPLE_W)) begin
        // Slot bit 0 is the I2S delay bit, so bit k carries sample[SAMPLE_W-k].
        din_d = sh_q[SAMPLE_W-1];
        sh_d  = {sh_q[SAMPLE_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q     <= '0;
      bit_cnt_q     <= BIT_W'(SLOT_W - 1);
      bclk_q        <= 1'b1;
      lrclk_q       <= 1'b1;
      din_q         <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      in_ready_q    <= 1'b0;
      sh_q          <= '0;
      hold_q        <= '0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      bclk_q        <= bclk_d;
      lrclk_q       <= lrclk_d;
      din_q         <= din_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      in_ready_q    <= in_ready_d;
      sh_q          <= sh_d;
      hold_q        <= hold_d;
    end
  end

  assign BCLK        = bclk_q;
  assign LRCLK       = lrclk_q;
  assign DIN         = din_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;
  assign in_ready    = in_ready_q;
endmodule
